rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Writer end of the CPU register-file write port.
- Merges two writeback sources into the single port (RF_W/Rdc/Rd):
  - Primary: ALU and immediate results, single-cycle, always accepted.
  - Long-latency: mul/div/load results, buffered in a small FIFO with a ready handshake.
- Exports a per-register pending mask so decode can interlock on registers with queued writes.

Parameters:
- FIFO_DEPTH, 4, long-latency queue entries; must be a power of 2, at least 2.
- DATA_W, 32, writeback data width.

Ports:
- WB_clk  in  1  clock; all state updates on posedge.
- WB_rst  in  1  asynchronous reset, active-high.
- A_valid  in  1  primary write request.
- A_addr  in  5  primary destination register.
- A_data  in  DATA_W  primary write data.
- L_valid  in  1  long-latency write request.
- L_ready  out  1  FIFO can accept; equals (count < FIFO_DEPTH).
- L_addr  in  5  long-latency destination register.
- L_data  in  DATA_W  long-latency write data.
- RF_W  out  1  register-file write enable (registered).
- Rdc  out  5  register-file write address (registered).
- Rd  out  DATA_W  register-file write data (registered).
- Pend  out  32  bit i set while a valid FIFO entry targets register i.
- L_cnt  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, WB_rst=1):
  - FIFO emptied; all entry valid bits cleared; read/write pointers = 0.
  - RF_W=0, Rdc=0, Rd=0, Pend=0, L_cnt=0, L_ready=1.
  - Reset mid-operation discards all queued writes; nothing is issued after release until new requests arrive.
- Long-latency accept:
  - L transfer occurs when L_valid && L_ready at posedge.
  - L_addr=0: handshake completes, entry is not enqueued (register $0 is never written).
  - Otherwise {addr, data, valid=1} is stored at the write pointer, and the pointer wraps modulo FIFO_DEPTH.
  - L_ready ignores a same-cycle pop: when full, L_ready=0 even if a pop happens that cycle.
- Issue selection each posedge, in priority order:
  1. A_valid && A_addr!=0: RF_W<=1, Rdc<=A_addr, Rd<=A_data.
  2. Else, FIFO non-empty: pop the head.
     - Head valid: RF_W<=1, Rdc/Rd <= head.
     - Head squashed (see optional feature): RF_W<=0.
  3. Else: RF_W<=0; Rdc and Rd hold their previous values.
- A_valid with A_addr=0 is ignored and counts as "no primary request", so the FIFO may pop that cycle.
- Latency:
  - Primary request: 1 cycle to RF_W; the register file commits on the following falling edge of that cycle.
  - Long-latency request: minimum 2 cycles (enqueue, then pop).
  - A continuous primary stream starves the FIFO; upstream guarantees gaps.
- Simultaneous push and pop: occupancy unchanged; a push into the slot being popped is legal only when the FIFO is not full.
- Ordering:
  - The FIFO drains strictly in order.
  - Without the optional feature, an A_valid whose A_addr has its Pend bit set is a protocol violation. Decode must stall on Pend[A_addr].
- Pend:
  - Combinational OR over valid FIFO entries of one-hot(addr).
  - Pend[0] is always 0.
  - A bit clears in the cycle after the last matching entry pops.

Optional Feature:
- Macro: RF_WB_SQUASH_EN.
- Defined:
  - An accepted primary write (A_valid, A_addr!=0) clears the valid bit of every FIFO entry with addr==A_addr on the same posedge.
  - Squashed entries still pop in order, consuming a slot and a cycle, with RF_W=0.
  - Pend drops those bits the next cycle.
  - An L entry pushed in the same cycle as the squash is not squashed.
- Not defined:
  - No squash logic; entry valid bits are always 1 while the entry is occupied.
  - Stale long-latency writes land after the younger primary write (protocol violation, as above).

Test Plan:
- Reset mid-queue: push 3 L writes ($5,$6,$7), assert WB_rst for 1 cycle -> RF_W=0, L_cnt=0, Pend=0, L_ready=1; no writes issued after release.
- Primary path: A_valid, A_addr=8, A_data=32'hDEAD_BEEF -> next cycle RF_W=1, Rdc=8, Rd=32'hDEAD_BEEF; A_addr=0 -> RF_W stays 0.
- Priority and backpressure (FIFO_DEPTH=4):
  - Hold A_valid every cycle while pushing L writes to $1..$5 -> L_ready=0 after the 4th push, the $5 push is held, Pend=32'h1E.
  - Drop A_valid -> $1,$2,$3,$4 issue in order on consecutive cycles, then $5.
- Wrap-around: run 10 push/pop pairs with data 0..9 -> pointers wrap, outputs appear in order 0..9, L_cnt never exceeds 1.
- Simultaneous push and pop at L_cnt=2 -> L_cnt stays 2; L_ready=0 at L_cnt=4 despite a same-cycle pop.
- RF_WB_SQUASH_EN:
  - Queue L writes to $9=1, $10=2, then A write $9=3 -> Rd sequence 3, (bubble with RF_W=0), 2; Pend[9] clears the cycle after the A write.
  - Same stimulus without the macro -> Rd sequence 3, 1, 2.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request/response bundle for rf_wb_arbiter
interface rf_wb_arbiter_if #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic              A_valid;
   logic [4:0]        A_addr;
   logic [DATA_W-1:0] A_data;
   logic              L_valid;
   logic              L_ready;
   logic [4:0]        L_addr;
   logic [DATA_W-1:0] L_data;
   logic              RF_W;
   logic [4:0]        Rdc;
   logic [DATA_W-1:0] Rd;
   logic [31:0]       Pend;
   logic [CW-1:0]     L_cnt;

   // Requester side: produces writeback requests, observes the register-file port
   modport master (
      output A_valid, A_addr, A_data, L_valid, L_addr, L_data,
      input  L_ready, RF_W, Rdc, Rd, Pend, L_cnt
   );

   // Arbiter side
   modport slave (
      input  A_valid, A_addr, A_data, L_valid, L_addr, L_data,
      output L_ready, RF_W, Rdc, Rd, Pend, L_cnt
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file writeback arbiter, primary path plus long-latency FIFO (option: RF_WB_SQUASH_EN)
module rf_wb_arbiter #(
   parameter int FIFO_DEPTH = 4,
   parameter int DATA_W     = 32
) (
   input  logic          WB_clk,
   input  logic          WB_rst,
   rf_wb_arbiter_if.slave wb
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [4:0]        addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] vld_q;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              rf_w_q, rf_w_d;
   logic [4:0]        rdc_q, rdc_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [31:0]       pend;

   logic a_fire, l_ready, push, pop;

   // The primary path always wins; the FIFO only pops in cycles without a real primary write
   assign a_fire  = wb.A_valid && (wb.A_addr != 5'd0);
   assign l_ready = (cnt_q < FULL);
   assign push    = wb.L_valid && l_ready && (wb.L_addr != 5'd0);
   assign pop     = !a_fire && (cnt_q != '0);

   assign wb.L_ready = l_ready;
   assign wb.RF_W    = rf_w_q;
   assign wb.Rdc     = rdc_q;
   assign wb.Rd      = rd_q;
   assign wb.Pend    = pend;
   assign wb.L_cnt   = cnt_q;

   // Pending mask: one-hot of every still-valid queued destination
   always_comb begin
      pend = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (vld_q[i]) pend[addr_q[i]] = 1'b1;
      end
      pend[0] = 1'b0;
   end

   // Issue selection and occupancy next-state
   always_comb begin
      rf_w_d = 1'b0;
      rdc_d  = rdc_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      if (a_fire) begin
         rf_w_d = 1'b1;
         rdc_d  = wb.A_addr;
         rd_d   = wb.A_data;
      end else if (pop && vld_q[rd_ptr_q]) begin
         rf_w_d = 1'b1;
         rdc_d  = addr_q[rd_ptr_q];
         rd_d   = data_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // FIFO storage, pointers and registered write port
   always_ff @(posedge WB_clk or posedge WB_rst) begin
      if (WB_rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         vld_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rf_w_q   <= 1'b0;
         rdc_q    <= '0;
         rd_q     <= '0;
      end else begin
`ifdef RF_WB_SQUASH_EN
         // A younger primary write makes queued writes to the same register stale
         if (a_fire) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               if (addr_q[i] == wb.A_addr) vld_q[i] <= 1'b0;
            end
         end
`endif
         if (pop) begin
            vld_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q        <= rd_ptr_q + 1'b1;
         end
         // Push last so a same-cycle entry is never squashed or cleared
         if (push) begin
            addr_q[wr_ptr_q] <= wb.L_addr;
            data_q[wr_ptr_q] <= wb.L_data;
            vld_q[wr_ptr_q]  <= 1'b1;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         cnt_q  <= cnt_d;
         rf_w_q <= rf_w_d;
         rdc_q  <= rdc_d;
         rd_q   <= rd_d;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int DW    = 32;

   logic WB_clk = 1'b0;
   logic WB_rst;

   rf_wb_arbiter_if #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) wb ();

   rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
      .WB_clk (WB_clk),
      .WB_rst (WB_rst),
      .wb     (wb)
   );

   always #5 WB_clk = ~WB_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      bit          vld;
   } ent_t;

   ent_t        mq[$];
   logic        m_rfw;
   logic [4:0]  m_rdc;
   logic [31:0] m_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_pend();
      logic [31:0] p;
      p = '0;
      foreach (mq[i]) if (mq[i].vld) p[mq[i].addr] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic set_a(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb.A_valid = v; wb.A_addr = a; wb.A_data = d;
   endtask

   task automatic set_l(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb.L_valid = v; wb.L_addr = a; wb.L_data = d;
   endtask

   task automatic step();
      bit   a_fire, l_fire;
      ent_t h;
      #1;
      check("l_ready", 32'(wb.L_ready), 32'(mq.size() < DEPTH));
      check("pend",    wb.Pend,         model_pend());
      check("l_cnt",   32'(wb.L_cnt),   32'(mq.size()));
      a_fire = wb.A_valid && (wb.A_addr != 5'd0);
      l_fire = wb.L_valid && (mq.size() < DEPTH);
      if (a_fire) begin
         m_rfw = 1'b1; m_rdc = wb.A_addr; m_rd = wb.A_data;
`ifdef RF_WB_SQUASH_EN
         foreach (mq[i]) if (mq[i].addr == wb.A_addr) mq[i].vld = 1'b0;
`endif
      end else if (mq.size() > 0) begin
         h = mq.pop_front();
         if (h.vld) begin
            m_rfw = 1'b1; m_rdc = h.addr; m_rd = h.data;
         end else begin
            m_rfw = 1'b0;
         end
      end else begin
         m_rfw = 1'b0;
      end
      if (l_fire && wb.L_addr != 5'd0) mq.push_back('{wb.L_addr, wb.L_data, 1'b1});
      @(posedge WB_clk);
      #1;
      check("rf_w", 32'(wb.RF_W), 32'(m_rfw));
      check("rdc",  32'(wb.Rdc),  32'(m_rdc));
      check("rd",   wb.Rd,        m_rd);
   endtask

   task automatic reset_checks();
      check("rst_rf_w",    32'(wb.RF_W),    32'd0);
      check("rst_rdc",     32'(wb.Rdc),     32'd0);
      check("rst_rd",      wb.Rd,           32'd0);
      check("rst_pend",    wb.Pend,         32'd0);
      check("rst_l_cnt",   32'(wb.L_cnt),   32'd0);
      check("rst_l_ready", 32'(wb.L_ready), 32'd1);
   endtask

   task automatic model_reset();
      mq.delete();
      m_rfw = 1'b0; m_rdc = '0; m_rd = '0;
   endtask

   task automatic drain();
      set_a(1'b0, 5'd0, 32'd0);
      set_l(1'b0, 5'd0, 32'd0);
      for (int i = 0; i < DEPTH + 2; i++) step();
   endtask

   initial begin
      set_a(1'b0, 5'd0, 32'd0);
      set_l(1'b0, 5'd0, 32'd0);
      WB_rst = 1'b1;
      model_reset();
      #2;
      reset_checks();
      @(posedge WB_clk);
      #1;
      WB_rst = 1'b0;

      // Primary path, then A_addr=0 ignored
      set_a(1'b1, 5'd8, 32'hDEAD_BEEF);
      step();
      check("prim_rf_w", 32'(wb.RF_W), 32'd1);
      check("prim_rdc",  32'(wb.Rdc),  32'd8);
      check("prim_rd",   wb.Rd,        32'hDEAD_BEEF);
      set_a(1'b1, 5'd0, 32'h1234_5678);
      step();
      check("a0_rf_w", 32'(wb.RF_W), 32'd0);
      check("a0_rd",   wb.Rd,        32'hDEAD_BEEF);

      // Reset mid-queue
      for (int k = 5; k <= 7; k++) begin
         set_a(1'b1, 5'd22, 32'(k));
         set_l(1'b1, 5'(k), 32'(100 + k));
         step();
      end
      check("midq_cnt", 32'(wb.L_cnt), 32'd3);
      set_a(1'b0, 5'd0, 32'd0);
      set_l(1'b0, 5'd0, 32'd0);
      #2;
      WB_rst = 1'b1;
      model_reset();
      #1;
      reset_checks();
      @(posedge WB_clk);
      #1;
      WB_rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_idle", 32'(wb.RF_W), 32'd0);
      end

      // Priority and backpressure
      for (int k = 1; k <= 4; k++) begin
         set_a(1'b1, 5'd20, 32'(200 + k));
         set_l(1'b1, 5'(k), 32'(k));
         step();
      end
      set_l(1'b1, 5'd5, 32'd5);
      #1;
      check("bp_l_ready", 32'(wb.L_ready), 32'd0);
      check("bp_pend",    wb.Pend,         32'h0000_001E);
      step();
      set_a(1'b0, 5'd0, 32'd0);
      step();
      check("bp_first", 32'(wb.Rdc), 32'd1);
      for (int k = 2; k <= 5; k++) begin
         step();
         set_l(1'b0, 5'd0, 32'd0);
         check("bp_order_rf_w", 32'(wb.RF_W), 32'd1);
         check("bp_order",      32'(wb.Rdc),  32'(k));
      end
      drain();

      // Wrap-around: push/pop pairs
      for (int k = 0; k < 10; k++) begin
         set_l(1'b1, 5'((k % 31) + 1), 32'(k));
         step();
         check("wrap_cnt_le1", 32'(wb.L_cnt <= 1), 32'd1);
         if (k > 0) check("wrap_rd", wb.Rd, 32'(k - 1));
      end
      set_l(1'b0, 5'd0, 32'd0);
      step();
      check("wrap_last", wb.Rd, 32'd9);
      drain();

      // Simultaneous push/pop at count 2, and at full
      for (int k = 0; k < 2; k++) begin
         set_a(1'b1, 5'd21, 32'(k));
         set_l(1'b1, 5'(11 + k), 32'(300 + k));
         step();
      end
      set_a(1'b0, 5'd0, 32'd0);
      set_l(1'b1, 5'd13, 32'd302);
      step();
      check("pushpop_cnt2", 32'(wb.L_cnt), 32'd2);
      drain();
      for (int k = 0; k < 4; k++) begin
         set_a(1'b1, 5'd21, 32'(k));
         set_l(1'b1, 5'(14 + k), 32'(400 + k));
         step();
      end
      set_a(1'b0, 5'd0, 32'd0);
      set_l(1'b1, 5'd18, 32'd404);
      #1;
      check("full_pop_l_ready", 32'(wb.L_ready), 32'd0);
      step();
      check("full_pop_cnt", 32'(wb.L_cnt), 32'd3);
      drain();

      // Squash scenario
      set_a(1'b1, 5'd20, 32'd0);
      set_l(1'b1, 5'd9, 32'd1);
      step();
      set_l(1'b1, 5'd10, 32'd2);
      step();
      set_l(1'b0, 5'd0, 32'd0);
      set_a(1'b1, 5'd9, 32'd3);
      step();
      check("sq_a_rd", wb.Rd, 32'd3);
      set_a(1'b0, 5'd0, 32'd0);
`ifdef RF_WB_SQUASH_EN
      #1;
      check("sq_pend9", 32'(wb.Pend[9]), 32'd0);
      step();
      check("sq_bubble", 32'(wb.RF_W), 32'd0);
`else
      #1;
      check("sq_pend9", 32'(wb.Pend[9]), 32'd1);
      step();
      check("sq_stale_rf_w", 32'(wb.RF_W), 32'd1);
      check("sq_stale_rd",   wb.Rd,        32'd1);
`endif
      step();
      check("sq_last_rd", wb.Rd, 32'd2);
      drain();

      // Randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         set_a($urandom_range(0, 99) < 35, 5'($urandom_range(0, 31)), $urandom);
         set_l($urandom_range(0, 99) < 60, 5'($urandom_range(0, 31)), $urandom);
         step();
      end
      drain();
      check("end_empty", 32'(wb.L_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
